// File: rtl/hsv_pkg.sv
// Shared widths, pixel types and hue constants for the RGB->HSV pipeline.
package hsv_pkg;

    localparam int HUE_W      = 9;
    localparam int COL_W      = 8;
    localparam int QUOT_W     = 8;
    localparam int DIV_STAGES = 8;
    localparam int SAT_DVD_W  = 16;
    localparam int HUE_DVD_W  = 14;
    localparam int LATENCY    = 1 + DIV_STAGES + 1;

    localparam int HUE_R    = 0;
    localparam int HUE_G    = 120;
    localparam int HUE_B    = 240;
    localparam int HUE_FULL = 360;

    typedef struct packed {
        logic [COL_W-1:0] r;
        logic [COL_W-1:0] g;
        logic [COL_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [HUE_W-1:0] h;
        logic [COL_W-1:0] s;
        logic [COL_W-1:0] v;
    } hsv_t;

    typedef enum logic [1:0] {
        SECT_R = 2'd0,
        SECT_G = 2'd1,
        SECT_B = 2'd2
    } sector_t;

    // Per-pixel context that rides alongside the two divider lanes.
    typedef struct packed {
        sector_t          sector;
        logic             neg;
        logic [COL_W-1:0] vmax;
        logic             delta_zero;
    } meta_t;

endpackage

// File: rtl/hsv_div_stage.sv
// One restoring-division step: brings down the dividend MSB and sets quotient bit STEP (MSB first).
module hsv_div_stage
    import hsv_pkg::*;
#(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8,
    parameter int STEP       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DIVISOR_W:0]    in_rem,
    input  logic [DIVIDEND_W-1:0] in_dividend,
    input  logic [DIVISOR_W-1:0]  in_divisor,
    input  logic [QUOT_W-1:0]     in_quot,
    output logic [DIVISOR_W:0]    out_rem,
    output logic [DIVIDEND_W-1:0] out_dividend,
    output logic [DIVISOR_W-1:0]  out_divisor,
    output logic [QUOT_W-1:0]     out_quot
);

    logic [DIVISOR_W+1:0] trial;
    logic [DIVISOR_W:0]   diff;
    logic                 fits;

    always_comb begin
        trial = {in_rem, in_dividend[DIVIDEND_W-1]};
        fits  = (trial >= {2'b00, in_divisor});
        diff  = trial[DIVISOR_W:0] - {1'b0, in_divisor};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_rem      <= '0;
            out_dividend <= '0;
            out_divisor  <= '0;
            out_quot     <= '0;
        end else if (en) begin
            out_rem      <= fits ? diff : trial[DIVISOR_W:0];
            out_dividend <= {in_dividend[DIVIDEND_W-2:0], 1'b0};
            out_divisor  <= in_divisor;
            out_quot     <= in_quot | (QUOT_W'(fits) << (QUOT_W - 1 - STEP));
        end
    end

endmodule

// File: rtl/rgb_to_hsv_pipe.sv
// Streaming RGB888 -> HSV converter: prep stage, two 8-step divider lanes, finish stage.
module rgb_to_hsv_pipe
    import hsv_pkg::*;
#(
    parameter int USER_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_r,
    input  logic [7:0]        in_g,
    input  logic [7:0]        in_b,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8:0]        out_h,
    output logic [7:0]        out_s,
    output logic [7:0]        out_v,
    output logic [USER_W-1:0] out_user
);

    logic en;
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    rgb_t              pix;
    sector_t           sector;
    logic [COL_W-1:0]  mx, mn, delta, abs_num;
    logic signed [COL_W:0] num;
    logic [SAT_DVD_W-1:0]  sat_dvd;
    logic [HUE_DVD_W-1:0]  hue_dvd;

    // Ties on the maximum resolve R > G > B because only a strictly larger channel takes over.
    always_comb begin
        pix    = {in_r, in_g, in_b};
        mx     = pix.r;
        sector = SECT_R;
        if (pix.g > mx) begin
            mx     = pix.g;
            sector = SECT_G;
        end
        if (pix.b > mx) begin
            mx     = pix.b;
            sector = SECT_B;
        end
        mn = pix.r;
        if (pix.g < mn) mn = pix.g;
        if (pix.b < mn) mn = pix.b;
        delta = mx - mn;
        case (sector)
            SECT_G:  num = $signed({1'b0, pix.b}) - $signed({1'b0, pix.r});
            SECT_B:  num = $signed({1'b0, pix.r}) - $signed({1'b0, pix.g});
            default: num = $signed({1'b0, pix.g}) - $signed({1'b0, pix.b});
        endcase
        abs_num = num[COL_W] ? COL_W'(-num) : num[COL_W-1:0];
        sat_dvd = {delta, {COL_W{1'b0}}} - {{COL_W{1'b0}}, delta};
        hue_dvd = {abs_num, 6'd0} - {4'd0, abs_num, 2'd0};
    end

    logic [DIV_STAGES:0] valid_q;
    meta_t               meta_q [0:DIV_STAGES];
    logic [USER_W-1:0]   user_q [0:DIV_STAGES];

    logic [COL_W:0]      sat_rem0, hue_rem0;
    logic [SAT_DVD_W-1:0] sat_dvd0;
    logic [HUE_DVD_W-1:0] hue_dvd0;
    logic [COL_W-1:0]    sat_div0, hue_div0;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            sat_rem0 <= '0;
            sat_dvd0 <= '0;
            sat_div0 <= '0;
            hue_rem0 <= '0;
            hue_dvd0 <= '0;
            hue_div0 <= '0;
            for (int k = 0; k <= DIV_STAGES; k++) begin
                meta_q[k] <= '0;
                user_q[k] <= '0;
            end
        end else if (en) begin
            valid_q   <= {valid_q[DIV_STAGES-1:0], in_valid};
            meta_q[0] <= '{sector: sector, neg: num[COL_W], vmax: mx, delta_zero: (delta == '0)};
            user_q[0] <= in_user;
            // The upper dividend bits seed the remainder; the quotient always fits in 8 bits.
            sat_rem0  <= {1'b0, sat_dvd[SAT_DVD_W-1:COL_W]};
            sat_dvd0  <= {sat_dvd[COL_W-1:0], {(SAT_DVD_W-COL_W){1'b0}}};
            sat_div0  <= mx;
            hue_rem0  <= {3'b000, hue_dvd[HUE_DVD_W-1:COL_W]};
            hue_dvd0  <= {hue_dvd[COL_W-1:0], {(HUE_DVD_W-COL_W){1'b0}}};
            hue_div0  <= delta;
            for (int k = 1; k <= DIV_STAGES; k++) begin
                meta_q[k] <= meta_q[k-1];
                user_q[k] <= user_q[k-1];
            end
        end
    end

    logic [COL_W:0]       sat_rem [0:DIV_STAGES];
    logic [SAT_DVD_W-1:0] sat_dv  [0:DIV_STAGES];
    logic [COL_W-1:0]     sat_ds  [0:DIV_STAGES];
    logic [QUOT_W-1:0]    sat_q   [0:DIV_STAGES];
    logic [COL_W:0]       hue_rem [0:DIV_STAGES];
    logic [HUE_DVD_W-1:0] hue_dv  [0:DIV_STAGES];
    logic [COL_W-1:0]     hue_ds  [0:DIV_STAGES];
    logic [QUOT_W-1:0]    hue_q   [0:DIV_STAGES];

    assign sat_rem[0] = sat_rem0;
    assign sat_dv[0]  = sat_dvd0;
    assign sat_ds[0]  = sat_div0;
    assign sat_q[0]   = '0;
    assign hue_rem[0] = hue_rem0;
    assign hue_dv[0]  = hue_dvd0;
    assign hue_ds[0]  = hue_div0;
    assign hue_q[0]   = '0;

    for (genvar k = 0; k < DIV_STAGES; k++) begin : g_div
        hsv_div_stage #(.DIVIDEND_W(SAT_DVD_W), .DIVISOR_W(COL_W), .STEP(k)) u_sat (
            .clk(clk), .reset(reset), .en(en),
            .in_rem(sat_rem[k]), .in_dividend(sat_dv[k]), .in_divisor(sat_ds[k]), .in_quot(sat_q[k]),
            .out_rem(sat_rem[k+1]), .out_dividend(sat_dv[k+1]), .out_divisor(sat_ds[k+1]),
            .out_quot(sat_q[k+1])
        );
        hsv_div_stage #(.DIVIDEND_W(HUE_DVD_W), .DIVISOR_W(COL_W), .STEP(k)) u_hue (
            .clk(clk), .reset(reset), .en(en),
            .in_rem(hue_rem[k]), .in_dividend(hue_dv[k]), .in_divisor(hue_ds[k]), .in_quot(hue_q[k]),
            .out_rem(hue_rem[k+1]), .out_dividend(hue_dv[k+1]), .out_divisor(hue_ds[k+1]),
            .out_quot(hue_q[k+1])
        );
    end

    meta_t               fin_meta;
    logic signed [HUE_W:0] base, hue_raw;
    logic [HUE_W-1:0]    hue_fin;
    hsv_t                result;

    // Masking on delta==0 / max==0 hides the divide-by-zero lanes.
    always_comb begin
        fin_meta = meta_q[DIV_STAGES];
        case (fin_meta.sector)
            SECT_G:  base = 10'(HUE_G);
            SECT_B:  base = 10'(HUE_B);
            default: base = 10'(HUE_R);
        endcase
        hue_raw = fin_meta.neg ? base - $signed({2'b00, hue_q[DIV_STAGES]})
                               : base + $signed({2'b00, hue_q[DIV_STAGES]});
        hue_fin = hue_raw[HUE_W-1:0];
        if (hue_raw < 0)
            hue_fin = HUE_W'(hue_raw + 10'(HUE_FULL));
        else if (hue_raw >= 10'(HUE_FULL))
            hue_fin = HUE_W'(hue_raw - 10'(HUE_FULL));
        result.h = fin_meta.delta_zero ? '0 : hue_fin;
        result.s = (fin_meta.vmax == '0) ? '0 : sat_q[DIV_STAGES];
        result.v = fin_meta.vmax;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_h     <= '0;
            out_s     <= '0;
            out_v     <= '0;
            out_user  <= '0;
        end else if (en) begin
            out_valid <= valid_q[DIV_STAGES];
            out_h     <= result.h;
            out_s     <= result.s;
            out_v     <= result.v;
            out_user  <= user_q[DIV_STAGES];
        end
    end

endmodule

// File: tb/tb_rgb_to_hsv_pipe.sv
// Scoreboard bench for rgb_to_hsv_pipe: directed vectors, backpressure, sideband and mid-stream reset.
module tb_rgb_to_hsv_pipe;

    localparam int LAT = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic [1:0] in_user = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_h;
    logic [7:0] out_s, out_v;
    logic [1:0] out_user;

    typedef struct {
        int h;
        int s;
        int v;
        int user;
        int cyc;
        bit chk_lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    exp_t        mdl_e;
    int          n_pass = 0;
    int          n_checks = 0;
    int          cyc = 0;
    bit          prev_stall = 0;
    logic [26:0] prev_word = '0;
    bit          stream_done = 0;
    int          rr, gg, bb, uu;

    // r, g, b, expected h, s, v
    int dir_tab [9][6] = '{
        '{255,   0,   0,   0, 255, 255},
        '{  0, 255,   0, 120, 255, 255},
        '{  0,   0, 255, 240, 255, 255},
        '{200, 100,  50,  20, 191, 200},
        '{255,   0, 128, 330, 255, 255},
        '{100, 100, 100,   0,   0, 100},
        '{  0,   0,   0,   0,   0,   0},
        '{255, 255,   0,  60, 255, 255},
        '{255,   0,   1,   0, 255, 255}
    };

    rgb_to_hsv_pipe #(.USER_W(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_h(out_h), .out_s(out_s), .out_v(out_v), .out_user(out_user)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Plain integer reference: C-style truncating division toward zero.
    function automatic exp_t ref_model(input int r, input int g, input int b, input int user);
        exp_t e;
        int   mx, mn, d;
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        mn = r;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
        d = mx - mn;
        e.v = mx;
        e.s = (mx == 0) ? 0 : (255 * d) / mx;
        if (d == 0)       e.h = 0;
        else if (r == mx) e.h = (60 * (g - b)) / d;
        else if (g == mx) e.h = 120 + (60 * (b - r)) / d;
        else              e.h = 240 + (60 * (r - g)) / d;
        if (e.h < 0)    e.h += 360;
        if (e.h >= 360) e.h -= 360;
        e.user    = user;
        e.cyc     = 0;
        e.chk_lat = 0;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the pixel.
    task automatic apply_stimulus(input int r, input int g, input int b, input int user,
                                  input int h, input int s, input int v, input bit chk);
        exp_t e;
        bit   accepted;
        in_r     = r[7:0];
        in_g     = g[7:0];
        in_b     = b[7:0];
        in_user  = user[1:0];
        in_valid = 1'b1;
        accepted = 0;
        for (int k = 0; k < 100 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                e.h = h; e.s = s; e.v = v; e.user = user;
                e.cyc = cyc; e.chk_lat = chk;
                exp_q.push_back(e);
                accepted = 1;
            end
        end
        if (!accepted) check_output("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_random(input int user);
        rr = $urandom_range(0, 255);
        gg = $urandom_range(0, 255);
        bb = $urandom_range(0, 255);
        mdl_e = ref_model(rr, gg, bb, user);
        apply_stimulus(rr, gg, bb, user, mdl_e.h, mdl_e.s, mdl_e.v, 1'b0);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check_output("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output side: protocol, stability and scoreboard comparison.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            check_output("in_ready", {31'd0, in_ready}, {31'd0, ~(out_valid & ~out_ready)});
            if (prev_stall) begin
                check_output("hold_valid", {31'd0, out_valid}, 1);
                check_output("hold_data", {5'd0, out_h, out_s, out_v, out_user}, {5'd0, prev_word});
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_output("spurious_out", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("out_h", {23'd0, out_h}, mon_e.h);
                    check_output("out_s", {24'd0, out_s}, mon_e.s);
                    check_output("out_v", {24'd0, out_v}, mon_e.v);
                    check_output("out_user", {30'd0, out_user}, mon_e.user);
                    if (mon_e.chk_lat) check_output("latency", cyc - mon_e.cyc, LAT);
                end
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_word  = {out_h, out_s, out_v, out_user};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("rst_out_valid", {31'd0, out_valid}, 0);
        check_output("rst_out_h", {23'd0, out_h}, 0);
        check_output("rst_out_s", {24'd0, out_s}, 0);
        check_output("rst_out_v", {24'd0, out_v}, 0);
        check_output("rst_out_user", {30'd0, out_user}, 0);
        check_output("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;

        $display("[TB] directed vectors, back-to-back");
        for (int i = 0; i < 9; i++)
            apply_stimulus(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], 0,
                           dir_tab[i][3], dir_tab[i][4], dir_tab[i][5], 1'b1);
        wait_drain();

        $display("[TB] random backpressure stream");
        stream_done = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) apply_random(0);
                stream_done = 1;
            end
            begin
                for (int k = 0; k < 500; k++) begin
                    if (stream_done && exp_q.size() == 0) break;
                    out_ready = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("[TB] sideband line of 16 pixels");
        for (int i = 0; i < 16; i++)
            apply_random((i == 0) ? 2 : ((i == 15) ? 1 : 0));
        wait_drain();

        $display("[TB] reset with pixels in flight");
        for (int i = 0; i < 5; i++) apply_random(0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_output("midrst_out_valid", {31'd0, out_valid}, 0);
        check_output("midrst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        apply_stimulus(200, 100, 50, 3, 20, 191, 200, 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
